// File: rtl/rs232_pkg.sv
// Shared definitions for the RS232 receive/transmit controllers.
package rs232_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACK  = 2'd1,
      WAIT = 2'd2
   } rx_state_e;

   localparam int CTL_FSEL    = 0;
   localparam int CTL_OVR_CLR = 1;

   // Values driven on fsel toward the receiver/transmitter
   localparam logic BAUD_19200  = 1'b0;
   localparam logic BAUD_115200 = 1'b1;

endpackage

// File: rtl/rs232_fifo.sv
// Synchronous first-word-fall-through byte FIFO with occupancy count.
module rs232_fifo #(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  logic [7:0]    i_din,
   input  logic          i_pop,
   output logic [7:0]    o_dout,
   output logic [AW:0]   o_count,
   output logic          o_full,
   output logic          o_empty
);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_head;
   logic [AW-1:0] r_tail;
   logic [AW:0]   r_count;
   logic          w_pop;
   logic          w_push;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign w_pop   = i_pop & ~o_empty;
   // A push while full is only legal when a pop frees the slot this cycle
   assign w_push  = i_push & (~o_full | w_pop);
   assign o_dout  = r_mem[r_head];
   assign o_count = r_count;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_tail] <= i_din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_tail <= r_tail + AW'(1'b1);
         end
         if (w_pop) begin
            r_head <= r_head + AW'(1'b1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1'b1);
            2'b01:   r_count <= r_count - (AW+1)'(1'b1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/rs232_rx_ctrl.sv
// RS232 receive-side controller: rdy/done handshake, byte FIFO, baud select.
// Optional RX_OVERRUN_CNT_EN adds an 8-bit saturating drop counter (ovr_cnt).
module rs232_rx_ctrl
   import rs232_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rx_rdy,
   input  logic [7:0]    rx_data,
   output logic          rx_done,
   output logic          fsel,
   input  logic          ctl_wr,
   input  logic [1:0]    ctl_wdata,
   input  logic          rd,
   output logic [7:0]    dout,
   output logic          avail,
   output logic          full,
   output logic [AW:0]   count,
   output logic          overrun
`ifdef RX_OVERRUN_CNT_EN
   ,
   output logic [7:0]    ovr_cnt
`endif
);

   rx_state_e r_state;
   logic      r_rx_done;
   logic      r_fsel;
   logic      r_overrun;
   logic      w_empty;
   logic      w_full;
   logic      w_capture;
   logic      w_pop_ok;
   logic      w_push;
   logic      w_drop;
   logic      w_ovr_clr;

   assign w_capture = (r_state == IDLE) & rx_rdy;
   assign w_pop_ok  = rd & ~w_empty;
   assign w_push    = w_capture & (~w_full | w_pop_ok);
   assign w_drop    = w_capture & ~w_push;
   assign w_ovr_clr = ctl_wr & ctl_wdata[CTL_OVR_CLR];

   rs232_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_din   (rx_data),
      .i_pop   (rd),
      .o_dout  (dout),
      .o_count (count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // WAIT holds off recapture until the receiver has released rdy
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_rx_done <= 1'b0;
      end else begin
         r_rx_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (rx_rdy) begin
                  r_state   <= ACK;
                  r_rx_done <= 1'b1;
               end else begin
                  r_state <= IDLE;
               end
            end
            ACK:     r_state <= WAIT;
            WAIT: begin
               if (!rx_rdy) begin
                  r_state <= IDLE;
               end else begin
                  r_state <= WAIT;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fsel    <= BAUD_19200;
         r_overrun <= 1'b0;
      end else begin
         if (ctl_wr) begin
            r_fsel <= ctl_wdata[CTL_FSEL];
         end
         if (w_drop) begin
            r_overrun <= 1'b1;
         end else if (w_ovr_clr) begin
            r_overrun <= 1'b0;
         end
      end
   end

`ifdef RX_OVERRUN_CNT_EN
   logic [7:0] r_ovr_cnt;

   // A drop coinciding with a clear leaves the count at one
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovr_cnt <= 8'd0;
      end else if (w_ovr_clr) begin
         r_ovr_cnt <= {7'd0, w_drop};
      end else if (w_drop && (r_ovr_cnt != 8'hFF)) begin
         r_ovr_cnt <= r_ovr_cnt + 8'd1;
      end
   end

   assign ovr_cnt = r_ovr_cnt;
`endif

   assign rx_done = r_rx_done;
   assign fsel    = r_fsel;
   assign overrun = r_overrun;
   assign avail   = ~w_empty;
   assign full    = w_full;

endmodule

// File: tb/tb_rs232_rx_ctrl.sv
// Scoreboard bench for rs232_rx_ctrl: expected bytes queued at send, checked on pop.
module tb_rs232_rx_ctrl;

   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          rx_rdy = 1'b0;
   logic [7:0]    rx_data = 8'h00;
   logic          ctl_wr = 1'b0;
   logic [1:0]    ctl_wdata = 2'b00;
   logic          rd = 1'b0;
   logic          rx_done;
   logic          fsel;
   logic [7:0]    dout;
   logic          avail;
   logic          full;
   logic [AW:0]   count;
   logic          overrun;
`ifdef RX_OVERRUN_CNT_EN
   logic [7:0]    ovr_cnt;
`endif

   int         n_checks = 0;
   int         n_errors = 0;
   int         done_cnt = 0;
   int         done_base;
   logic [7:0] exp_q[$];
   logic [7:0] exp_b;

   rs232_rx_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_rdy    (rx_rdy),
      .rx_data   (rx_data),
      .rx_done   (rx_done),
      .fsel      (fsel),
      .ctl_wr    (ctl_wr),
      .ctl_wdata (ctl_wdata),
      .rd        (rd),
      .dout      (dout),
      .avail     (avail),
      .full      (full),
      .count     (count),
      .overrun   (overrun)
`ifdef RX_OVERRUN_CNT_EN
      ,
      .ovr_cnt   (ovr_cnt)
`endif
   );

   always #20 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: counts done pulses and checks every accepted pop against the queue
   always @(negedge clk) begin
      if (rx_done) done_cnt++;
      if (rd && avail && !rst) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL pop_underflow: got dout %0h expected no data", dout);
         end else begin
            exp_b = exp_q.pop_front();
            check("pop_dout", {24'd0, dout}, {24'd0, exp_b});
         end
      end
   end

   task automatic wait_done();
      bit ok = 1'b0;
      for (int i = 0; i < 6 && !ok; i++) begin
         if (rx_done) ok = 1'b1;
         else begin
            @(posedge clk); #1;
         end
      end
      if (!ok) begin
         n_checks++;
         n_errors++;
         $display("FAIL done_timeout: got no rx_done expected pulse");
      end
   endtask

   // Drive one byte through the handshake; receiver drops rdy the cycle after done
   task automatic send_byte(input logic [7:0] b, input bit do_rd);
      if (exp_q.size() < DEPTH || (do_rd && exp_q.size() > 0)) exp_q.push_back(b);
      rx_data = b;
      rx_rdy  = 1'b1;
      rd      = do_rd;
      @(posedge clk); #1;
      rd = 1'b0;
      wait_done();
      @(posedge clk); #1;
      rx_rdy = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic pop_one();
      rd = 1'b1;
      @(posedge clk); #1;
      rd = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_done", {31'd0, rx_done}, 32'd0);
      check("rst_fsel", {31'd0, fsel}, 32'd0);
      check("rst_count", {27'd0, count}, 32'd0);
      check("rst_avail", {31'd0, avail}, 32'd0);
      check("rst_full", {31'd0, full}, 32'd0);
      check("rst_overrun", {31'd0, overrun}, 32'd0);

      // Test 1: single byte with cycle-exact timing
      done_base = done_cnt;
      exp_q.push_back(8'hA5);
      rx_data = 8'hA5;
      rx_rdy  = 1'b1;
      @(posedge clk); #1;
      check("t1_done_n1", {31'd0, rx_done}, 32'd1);
      check("t1_avail_n1", {31'd0, avail}, 32'd1);
      check("t1_dout_n1", {24'd0, dout}, 32'hA5);
      check("t1_count_n1", {27'd0, count}, 32'd1);
      @(posedge clk); #1;
      rx_rdy = 1'b0;
      check("t1_done_n2", {31'd0, rx_done}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("t1_done_pulses", done_cnt - done_base, 32'd1);
      check("t1_count_hold", {27'd0, count}, 32'd1);
      pop_one();
      check("t1_count_after_pop", {27'd0, count}, 32'd0);

      // Test 2: five bytes in order, then an extra rd on empty
      for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b0);
      check("t2_count5", {27'd0, count}, 32'd5);
      for (int i = 4; i >= 0; i--) begin
         pop_one();
         check("t2_count_dec", {27'd0, count}, i);
      end
      check("t2_avail_empty", {31'd0, avail}, 32'd0);
      pop_one();
      check("t2_count_extra_rd", {27'd0, count}, 32'd0);
      check("t2_avail_extra_rd", {31'd0, avail}, 32'd0);

      // Test 3: overflow by one byte, then clear overrun
      for (int i = 0; i < 17; i++) send_byte(8'h10 + 8'(i), 1'b0);
      check("t3_full", {31'd0, full}, 32'd1);
      check("t3_count", {27'd0, count}, 32'd16);
      check("t3_overrun", {31'd0, overrun}, 32'd1);
      check("t3_head", {24'd0, dout}, 32'h10);
`ifdef RX_OVERRUN_CNT_EN
      check("t3_ovr_cnt", {24'd0, ovr_cnt}, 32'd1);
`endif
      ctl_wr    = 1'b1;
      ctl_wdata = 2'b10;
      @(posedge clk); #1;
      ctl_wr = 1'b0;
      check("t3_overrun_clr", {31'd0, overrun}, 32'd0);
      check("t3_fsel_low", {31'd0, fsel}, 32'd0);
`ifdef RX_OVERRUN_CNT_EN
      check("t3_ovr_cnt_clr", {24'd0, ovr_cnt}, 32'd0);
`endif

      // Test 4: push while full with a simultaneous pop
      send_byte(8'h77, 1'b1);
      check("t4_overrun", {31'd0, overrun}, 32'd0);
      check("t4_count", {27'd0, count}, 32'd16);
      check("t4_full", {31'd0, full}, 32'd1);
      check("t4_head", {24'd0, dout}, 32'h11);
      for (int i = 0; i < 16; i++) begin
         if (i == 15) check("t4_tail_byte", {24'd0, dout}, 32'h77);
         pop_one();
      end
      check("t4_drained", {31'd0, avail}, 32'd0);

      // Test 5: fsel write, then reset mid-WAIT with rdy held
      ctl_wr    = 1'b1;
      ctl_wdata = 2'b01;
      @(posedge clk); #1;
      ctl_wr = 1'b0;
      check("t5_fsel_set", {31'd0, fsel}, 32'd1);
      rx_data = 8'h5A;
      rx_rdy  = 1'b1;
      @(posedge clk); #1;
      wait_done();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      exp_q.delete();
      check("t5_rst_fsel", {31'd0, fsel}, 32'd0);
      check("t5_rst_count", {27'd0, count}, 32'd0);
      check("t5_rst_done", {31'd0, rx_done}, 32'd0);
      done_base = done_cnt;
      exp_q.push_back(8'h5A);
      rst = 1'b0;
      @(posedge clk); #1;
      wait_done();
      @(posedge clk); #1;
      rx_rdy = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("t5_fresh_done", done_cnt - done_base, 32'd1);
      check("t5_count_once", {27'd0, count}, 32'd1);
      check("t5_dout", {24'd0, dout}, 32'h5A);
      pop_one();
      check("queue_drained", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
